// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
// Block-level handshake bundle for the AES-128 round controller.
//
// Handshake rules (both channels):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer holds valid and its data stable until that edge.
//   The consumer may raise or lower ready freely.
//   Input channel : in_valid / in_ready carry Plaintext + Key.
//   Output channel: out_valid / out_ready carry Output.
//
// Signals
//   in_valid   plaintext/key pair valid (upstream -> controller)
//   in_ready   controller can accept a block
//   Plaintext  128-bit input block, byte 0 in bits [127:120]
//   Key        128-bit cipher key, same byte order
//   out_valid  ciphertext valid
//   out_ready  downstream accepts ciphertext
//   Output     128-bit ciphertext
// Modports
//   master : upstream/downstream side (drives the block in, takes the result)
//   slave  : the controller
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] Plaintext;
    logic [127:0] Key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] Output;

    modport master (
        output in_valid, Plaintext, Key, out_ready,
        input  in_ready, out_valid, Output
    );

    modport slave (
        input  in_valid, Plaintext, Key, out_ready,
        output in_ready, out_valid, Output
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES-128 encryption sequencer. Holds the 128-bit state and the
// round key, and steps an external combinational round datapath plus an
// external key-expansion step through rounds 1..NR, one round per clock.
//
// Ports
//   clk, rst_n  clock (rising edge) / asynchronous active-low reset
//   host        aes_round_ctrl_if.slave: block in, ciphertext out
//   abort       synchronous abandon of the current block, any state
//   dp_state    state register, drives the round datapath
//   dp_last     final round; datapath must skip MixColumns
//   round_key   round-key register, drives key expansion
//   rcon        round constant for the key-expansion step
//   next_key    key expansion result: round key for round_idx
//   round_in    datapath result: round(dp_state, next_key)
//   round_idx   current round number, 0 when idle
//   busy        high while a block is in flight (ROUND or DONE)
//   dbg_state   encoded FSM state (0 IDLE, 1 ROUND, 2 DONE)
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_round_ctrl_if.slave      host,
    input  logic                 abort,
    output logic [127:0]         dp_state,
    output logic                 dp_last,
    output logic [127:0]         round_key,
    output logic [7:0]           rcon,
    input  logic [127:0]         next_key,
    input  logic [127:0]         round_in,
    output logic [3:0]           round_idx,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;

    // abort beats in_valid, so an aborted IDLE cycle never samples a block.
    assign accept = (state == IDLE) && host.in_valid && !abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (host.in_valid)            state_nxt = ROUND;
                ROUND:   if (round_idx == LAST_ROUND)  state_nxt = DONE;
                DONE:    if (host.out_ready)           state_nxt = IDLE;
                default:                               state_nxt = IDLE;
            endcase
        end
    end

    // Outputs. in_ready is gated by rst_n so it reads 0 while reset is held
    // and rises straight out of IDLE once reset releases.
    always_comb begin
        host.in_ready  = rst_n && (state == IDLE);
        host.out_valid = (state == DONE);
        host.Output    = (state == DONE) ? dp_state : '0;
        busy           = (state != IDLE);
        dp_last        = (state == ROUND) && (round_idx == LAST_ROUND);
        dbg_state      = state;
    end

    // Data registers. On abort only the round counter is cleared; state and
    // key are left as they were since nothing downstream can observe them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_state  <= '0;
            round_key <= '0;
            round_idx <= '0;
        end else if (abort) begin
            round_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dp_state  <= host.Plaintext ^ host.Key;
                        round_key <= host.Key;
                        round_idx <= 4'd1;
                    end
                end
                ROUND: begin
                    dp_state  <= round_in;
                    round_key <= next_key;
                    if (round_idx != LAST_ROUND) begin
                        round_idx <= round_idx + 4'd1;
                    end
                end
                DONE: begin
                    if (host.out_ready) begin
                        round_idx <= '0;
                    end
                end
                default: round_idx <= '0;
            endcase
        end
    end

    // Round constant for the key-expansion step that produces round_idx's key.
    always_comb begin
        case (round_idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Bench for aes_round_ctrl. Provides a golden AES-128 round datapath and
// key-expansion step, plus an independent full-block reference used to
// fill the expected-ciphertext queue whenever a block is accepted.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

    // ------------------------------------------------------------ clock/reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------------ DUT
    logic [127:0] dp_state, round_key, next_key, round_in;
    logic         dp_last, busy;
    logic [7:0]   rcon;
    logic [3:0]   round_idx;
    logic [1:0]   dbg_state;

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (bus),
        .abort     (abort),
        .dp_state  (dp_state),
        .dp_last   (dp_last),
        .round_key (round_key),
        .rcon      (rcon),
        .next_key  (next_key),
        .round_in  (round_in),
        .round_idx (round_idx),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------ AES model
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv  = 8'h01;
        logic [7:0] base = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = subword({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [7:0] rc_of(input int r);
        case (r)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] key);
        logic [127:0] s = p ^ key;
        logic [127:0] k = key;
        for (int r = 1; r <= 10; r++) begin
            k = key_step(k, rc_of(r));
            s = aes_round(s, k, r == 10);
        end
        return s;
    endfunction

    // Golden external datapath driven from the controller's registers.
    assign next_key = key_step(round_key, rcon);
    assign round_in = aes_round(dp_state, next_key, dp_last);

    // ------------------------------------------------------------ scoreboard
    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;
    int n_acc   = 0;
    int last_acc_cyc = 0;
    bit ii_on   = 1'b0;
    bit have_prev = 1'b0;
    logic [127:0] exp_q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Accept side: the values present now are the ones the next edge samples.
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready && !abort) begin
            exp_q.push_back(aes_enc(bus.Plaintext, bus.Key));
            n_acc++;
            if (ii_on && have_prev) chk("accept_interval", 128'(cyc - last_acc_cyc), 128'(12));
            last_acc_cyc = cyc;
            have_prev    = 1'b1;
        end
    end

    // Output side: abort alongside out_ready is not a transfer.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !abort) begin
            n_xfer++;
            if (exp_q.size() == 0) chk("expected_queue_nonempty", 128'(exp_q.size()), 128'(1));
            else                   chk("ciphertext", bus.Output, exp_q.pop_front());
        end
    end

    // ------------------------------------------------------------ driver tasks
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] p, input logic [127:0] k);
        int n = 0;
        while (!bus.in_ready && n < 100) begin tick(); n++; end
        chk("in_ready_before_accept", 128'(bus.in_ready), 128'(1));
        bus.in_valid  = 1'b1;
        bus.Plaintext = p;
        bus.Key       = k;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.out_valid && n < 100) begin tick(); n++; end
        chk("out_valid_reached", 128'(bus.out_valid), 128'(1));
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_round_idx"}, 128'(round_idx), 128'(0));
        chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        chk({tag, "_in_ready"},  128'(bus.in_ready), 128'(1));
        chk({tag, "_busy"},      128'(busy), 128'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dp_state"},  dp_state, 128'(0));
        chk({tag, "_round_key"}, round_key, 128'(0));
        chk({tag, "_output"},    bus.Output, 128'(0));
        chk({tag, "_round_idx"}, 128'(round_idx), 128'(0));
        chk({tag, "_rcon"},      128'(rcon), 128'(0));
        chk({tag, "_in_ready"},  128'(bus.in_ready), 128'(0));
        chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        chk({tag, "_busy"},      128'(busy), 128'(0));
        chk({tag, "_dp_last"},   128'(dp_last), 128'(0));
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ main
    initial begin
        int x0;
        int a0;
        int n;
        bus.in_valid  = 1'b0;
        bus.Plaintext = '0;
        bus.Key       = '0;
        bus.out_ready = 1'b0;

        // Reset values while rst_n is held low.
        #2;
        chk_reset_vals("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk_idle("after_reset");

        // 1: FIPS-197 C.1, round-by-round visibility of rcon/dp_last.
        accept(P1, K1);
        for (int j = 1; j <= 10; j++) begin
            chk("t1_round_idx", 128'(round_idx), 128'(j));
            chk("t1_rcon", 128'(rcon), 128'(rc_of(j)));
            chk("t1_dp_last", 128'(dp_last), 128'(j == 10));
            chk("t1_out_valid_early", 128'(bus.out_valid), 128'(0));
            tick();
        end
        chk("t1_out_valid", 128'(bus.out_valid), 128'(1));
        chk("t1_output", bus.Output, C1);
        chk("t1_round_idx_done", 128'(round_idx), 128'(10));
        chk("t1_dp_last_done", 128'(dp_last), 128'(0));
        chk("t1_in_ready_done", 128'(bus.in_ready), 128'(0));
        drain();
        chk_idle("t1_end");
        chk("t1_xfer_count", 128'(n_xfer), 128'(1));

        // 2: FIPS-197 B with 20 cycles of backpressure.
        accept(P2, K2);
        wait_done();
        for (int j = 0; j < 20; j++) begin
            chk("t2_output_hold", bus.Output, C2);
            chk("t2_in_ready", 128'(bus.in_ready), 128'(0));
            chk("t2_out_valid", 128'(bus.out_valid), 128'(1));
            tick();
        end
        x0 = n_xfer;
        drain();
        chk("t2_single_xfer", 128'(n_xfer), 128'(x0 + 1));
        chk("t2_in_ready_after", 128'(bus.in_ready), 128'(1));
        repeat (3) tick();
        chk("t2_no_repeat", 128'(n_xfer), 128'(x0 + 1));

        // 3: abort at round 5, then a clean vector-1 block.
        accept(P1, K1);
        repeat (4) tick();
        chk("t3_round_idx_5", 128'(round_idx), 128'(5));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        void'(exp_q.pop_back());   // aborted block never produces output
        chk_idle("t3_abort");
        for (int j = 0; j < 15; j++) begin
            chk("t3_no_out_valid", 128'(bus.out_valid), 128'(0));
            tick();
        end
        accept(P1, K1);
        wait_done();
        chk("t3_output", bus.Output, C1);
        drain();

        // 4: asynchronous reset at round 7.
        accept(P1, K1);
        repeat (6) tick();
        chk("t4_round_idx_7", 128'(round_idx), 128'(7));
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("t4_reset");
        void'(exp_q.pop_back());
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk_idle("t4_release");
        for (int j = 0; j < 15; j++) begin
            chk("t4_no_out_valid", 128'(bus.out_valid), 128'(0));
            tick();
        end

        // 5: in_valid held high with fresh random data every cycle.
        a0 = n_acc;
        x0 = n_xfer;
        have_prev = 1'b0;
        ii_on = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int j = 0; j < 62; j++) begin
            bus.Plaintext = {$urandom, $urandom, $urandom, $urandom};
            bus.Key       = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (busy && n < 30) begin tick(); n++; end
        chk("t5_drained", 128'(busy), 128'(0));
        ii_on = 1'b0;
        bus.out_ready = 1'b0;
        chk("t5_accepts", 128'(n_acc - a0), 128'(6));
        chk("t5_xfers_match", 128'(n_xfer - x0), 128'(n_acc - a0));

        // 6: abort together with out_ready in DONE.
        accept(P2, K2);
        wait_done();
        x0 = n_xfer;
        abort = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        abort = 1'b0;
        bus.out_ready = 1'b0;
        void'(exp_q.pop_back());
        chk_idle("t6_abort");
        chk("t6_no_xfer", 128'(n_xfer), 128'(x0));
        tick();
        chk("t6_output_cleared", bus.Output, 128'(0));

        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption sequencer. It owns the 128-bit state register and the round-key register. It steps one external combinational round datapath (SubBytes -> shiftRowsE -> MixColumns -> AddRoundKey) and one external key-expansion step through rounds 1..10. It accepts a plaintext/key pair over a valid/ready handshake and presents the ciphertext over a valid/ready handshake.

Parameters:
NR, 10, number of rounds; fixed at 10 for AES-128; other values unsupported.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  plaintext/key pair valid
in_ready  out  1  controller can accept a block
Plaintext  in  128  input block, byte 0 in bits [127:120]
Key  in  128  cipher key, same byte order
abort  in  1  synchronous abandon of the current block
dp_state  out  128  current state register, drives the round datapath
dp_last  out  1  final round; datapath must bypass MixColumns
round_key  out  128  current round-key register, drives key expansion
rcon  out  8  round constant for the key-expansion step
next_key  in  128  key expansion result: round key for round_idx
round_in  in  128  datapath result: round(dp_state, next_key)
round_idx  out  4  current round number, 0 when idle
busy  out  1  high in ROUND or DONE
out_valid  out  1  ciphertext valid
out_ready  in  1  downstream accepts ciphertext
Output  out  128  ciphertext, equals dp_state while out_valid

Behaviour:
- State machine has three states: IDLE, ROUND, DONE.
- Reset (asynchronous, rst_n=0) values:
  - FSM goes to IDLE.
  - dp_state, round_key, and Output are 0.
  - round_idx is 0; rcon is 0x00.
  - in_ready, out_valid, busy, and dp_last are 0.
  - After reset deasserts, in_ready rises combinationally from the IDLE state.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: dp_state <= Plaintext^Key (initial AddRoundKey), round_key <= Key, round_idx <= 1, go to ROUND.
- ROUND, one round per cycle:
  - dp_state <= round_in; round_key <= next_key.
  - If round_idx==NR: go to DONE and hold round_idx at NR. Otherwise round_idx <= round_idx+1.
- rcon is a combinational lookup on round_idx:
  - rounds 1..10 give 01,02,04,08,10,20,40,80,1b,36;
  - any other value gives 00.
- dp_last = (state==ROUND && round_idx==NR).
- DONE:
  - out_valid=1 and Output=dp_state.
  - Output holds stable while out_valid=1 and out_ready=0; backpressure may last indefinitely.
  - On out_ready=1: go to IDLE and set round_idx <= 0.
  - dp_state stays unchanged until the next accept.
- Latency:
  - Accept at edge k; rounds update at edges k+1..k+10; out_valid is high after edge k+10.
  - Minimum initiation interval is 12 cycles; there is no back-to-back overlap.
  - in_ready is 0 in ROUND and DONE, including the cycle in which out_ready completes the handshake.
- abort:
  - Effective in any state at the clock edge: go to IDLE, round_idx <= 0, out_valid falls next cycle; dp_state and round_key are left unchanged.
  - abort in IDLE together with in_valid: abort wins and nothing is accepted.
  - abort in DONE together with out_ready: counts as abort, not a completed transfer; the bench must not count it as one.
- Reset mid-operation (any state): outputs return immediately to their reset values; no partial result is ever presented.
- Width rules:
  - round_idx is 4 bits and never exceeds NR.
  - No arithmetic is done on the data path inside this block other than the initial XOR.

Test Plan:
1. FIPS-197 C.1 vector with a golden datapath and key-expansion model:
   - Stimulus: Plaintext=00112233445566778899aabbccddeeff, Key=000102030405060708090a0b0c0d0e0f.
   - Required: out_valid high exactly 10 cycles after the accept edge; Output=69c4e0d86a7b0430d8cdb78070b4c55a.
   - Required: rcon sequence 01..36 is observed over the 10 rounds; dp_last is high only in round 10.
2. FIPS-197 B vector with out_ready held low for 20 cycles:
   - Stimulus: Plaintext=3243f6a8885a308d313198a2e0370734, Key=2b7e151628aed2a6abf7158809cf4f3c.
   - Required: Output=3925841d02dc09fbdc118597196a0b32, held stable throughout; in_ready stays 0; release gives a single transfer.
3. abort asserted at round_idx=5 -> IDLE next cycle, round_idx=0, no out_valid. A new accept then yields the correct vector-1 ciphertext.
4. rst_n pulsed low at round_idx=7 -> all outputs are 0 asynchronously, in_ready=1 after release, no spurious out_valid.
5. in_valid held high continuously with out_ready=1:
   - Required: accepts occur every 12 cycles exactly.
   - Required: in_valid while busy is ignored; no Plaintext is sampled during ROUND or DONE.
6. Simultaneous abort+out_ready in DONE -> IDLE next cycle, and the scoreboard records no completed transfer.
